regfile_2r1w_vld: RTL and testbench

Parametrised register file, next generation of the team's single-port regfile. Adds:
- Two independent registered read ports, one byte-strobed write port.
- Write-to-read bypass.
- Per-entry valid bits with an invalidate port and a live count of valid entries.
- Optional hardwired-zero entry 0.

Sits between the datapath and control as the operand store with scoreboard-style valid tracking.

---
 rtl/regfile_2r1w_vld.sv | 140 ++++++++++++++
 tb/tb_regfile_2r1w_vld.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_vld.sv
// regfile_2r1w_vld: parametrised register file with two registered read
// ports, one byte-strobed write port, per-entry valid bits, an invalidate
// port and a live count of valid entries. Optional hardwired-zero entry 0.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   w_en/w_addr/w_data write request, address, data
//   w_be               byte enables, bit k covers w_data[8k+7:8k]
//   inv_en/inv_addr    invalidate request and address
//   ra_en/ra_addr      read port A request; ra_data/ra_vld registered result
//   rb_en/rb_addr      read port B request; rb_data/rb_vld registered result
//   valid_cnt          registered number of valid entries
module regfile_2r1w_vld #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned ADDR     = 3,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               w_en,
   input  logic [ADDR-1:0]    w_addr,
   input  logic [WIDTH-1:0]   w_data,
   input  logic [WIDTH/8-1:0] w_be,
   input  logic               inv_en,
   input  logic [ADDR-1:0]    inv_addr,
   input  logic               ra_en,
   input  logic [ADDR-1:0]    ra_addr,
   output logic [WIDTH-1:0]   ra_data,
   output logic               ra_vld,
   input  logic               rb_en,
   input  logic [ADDR-1:0]    rb_addr,
   output logic [WIDTH-1:0]   rb_data,
   output logic               rb_vld,
   output logic [ADDR:0]      valid_cnt
);

   localparam int unsigned NBYTES = WIDTH / 8;
   localparam logic [ADDR:0] CNT_ONE = {{ADDR{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;

   logic             w_ok;
   logic             inv_ok;
   logic             w_act;
   logic             inv_act;
   logic             cnt_inc;
   logic             cnt_dec;
   logic [WIDTH-1:0] w_word;
   logic [WIDTH-1:0] ra_data_d;
   logic             ra_vld_d;
   logic [WIDTH-1:0] rb_data_d;
   logic             rb_vld_d;

   // Next state of the whole array after this cycle's write/invalidate.
   always_comb begin
      w_ok   = 1'b1;
      inv_ok = 1'b1;
      if (ZERO_REG != 0) begin
         w_ok   = (w_addr != '0);
         inv_ok = (inv_addr != '0);
      end
      w_act   = w_en && w_ok;
      // A write to the same entry wins over the invalidate.
      inv_act = inv_en && inv_ok && !(w_act && (w_addr == inv_addr));

      // Merge from the current content, not the invalidated one.
      w_word = mem_q[w_addr];
      for (int k = 0; k < NBYTES; k++) begin
         if (w_be[k]) begin
            w_word[8*k +: 8] = w_data[8*k +: 8];
         end
      end

      mem_d = mem_q;
      vld_d = vld_q;
      if (inv_act) begin
         mem_d[inv_addr] = '0;
         vld_d[inv_addr] = 1'b0;
      end
      if (w_act) begin
         mem_d[w_addr] = w_word;
         vld_d[w_addr] = 1'b1;
      end

      // Entry 0 never becomes valid when hardwired, so it drops out of the count.
      cnt_inc = w_act && !vld_q[w_addr];
      cnt_dec = inv_act && vld_q[inv_addr];
   end

   // Write-first bypass: reads observe the next state.
   always_comb begin
      ra_data_d = mem_d[ra_addr];
      ra_vld_d  = vld_d[ra_addr];
      rb_data_d = mem_d[rb_addr];
      rb_vld_d  = vld_d[rb_addr];
      if (ZERO_REG != 0) begin
         if (ra_addr == '0) begin
            ra_data_d = '0;
            ra_vld_d  = 1'b1;
         end
         if (rb_addr == '0) begin
            rb_data_d = '0;
            rb_vld_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q     <= '{default: '0};
         vld_q     <= '0;
         ra_data   <= '0;
         ra_vld    <= 1'b0;
         rb_data   <= '0;
         rb_vld    <= 1'b0;
         valid_cnt <= '0;
      end else begin
         mem_q <= mem_d;
         vld_q <= vld_d;
         if (ra_en) begin
            ra_data <= ra_data_d;
            ra_vld  <= ra_vld_d;
         end
         if (rb_en) begin
            rb_data <= rb_data_d;
            rb_vld  <= rb_vld_d;
         end
         case ({cnt_inc, cnt_dec})
            2'b10:   valid_cnt <= valid_cnt + CNT_ONE;
            2'b01:   valid_cnt <= valid_cnt - CNT_ONE;
            default: valid_cnt <= valid_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_2r1w_vld.sv
// tb_regfile_2r1w_vld: table-driven bench for regfile_2r1w_vld. A default
// instance (ZERO_REG=0) is checked through a scoreboard queue fed from the
// vector table; a ZERO_REG=1 instance shares the inputs and is checked by a
// short hand-written sequence.
module tb_regfile_2r1w_vld;

   logic        clk = 1'b0;
   logic        rst;
   logic        w_en;
   logic [2:0]  w_addr;
   logic [15:0] w_data;
   logic [1:0]  w_be;
   logic        inv_en;
   logic [2:0]  inv_addr;
   logic        ra_en;
   logic [2:0]  ra_addr;
   logic        rb_en;
   logic [2:0]  rb_addr;

   logic [15:0] ra_data, rb_data, z_ra_data, z_rb_data;
   logic        ra_vld, rb_vld, z_ra_vld, z_rb_vld;
   logic [3:0]  valid_cnt, z_valid_cnt;

   always #5 clk = ~clk;

   regfile_2r1w_vld #(.DEPTH(8), .WIDTH(16), .ADDR(3), .ZERO_REG(0)) dut (
      .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
      .inv_en(inv_en), .inv_addr(inv_addr), .ra_en(ra_en), .ra_addr(ra_addr),
      .ra_data(ra_data), .ra_vld(ra_vld), .rb_en(rb_en), .rb_addr(rb_addr),
      .rb_data(rb_data), .rb_vld(rb_vld), .valid_cnt(valid_cnt)
   );

   regfile_2r1w_vld #(.DEPTH(8), .WIDTH(16), .ADDR(3), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
      .inv_en(inv_en), .inv_addr(inv_addr), .ra_en(ra_en), .ra_addr(ra_addr),
      .ra_data(z_ra_data), .ra_vld(z_ra_vld), .rb_en(rb_en), .rb_addr(rb_addr),
      .rb_data(z_rb_data), .rb_vld(z_rb_vld), .valid_cnt(z_valid_cnt)
   );

   typedef struct {
      logic        rst;
      logic        w_en;
      logic [2:0]  w_addr;
      logic [15:0] w_data;
      logic [1:0]  w_be;
      logic        inv_en;
      logic [2:0]  inv_addr;
      logic        ra_en;
      logic [2:0]  ra_addr;
      logic        rb_en;
      logic [2:0]  rb_addr;
      logic [15:0] e_ra;
      logic        e_rav;
      logic [15:0] e_rb;
      logic        e_rbv;
      logic [3:0]  e_cnt;
   } vec_t;

   typedef struct {
      logic [15:0] ra;
      logic        rav;
      logic [15:0] rb;
      logic        rbv;
      logic [3:0]  cnt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(
      input logic rst_i, input logic we, input logic [2:0] wa, input logic [15:0] wd,
      input logic [1:0] be, input logic ie, input logic [2:0] ia,
      input logic rae, input logic [2:0] raa, input logic rbe, input logic [2:0] rba,
      input logic [15:0] era, input logic erav, input logic [15:0] erb, input logic erbv,
      input logic [3:0] ecnt);
      vec_t v;
      v.rst = rst_i; v.w_en = we; v.w_addr = wa; v.w_data = wd; v.w_be = be;
      v.inv_en = ie; v.inv_addr = ia; v.ra_en = rae; v.ra_addr = raa;
      v.rb_en = rbe; v.rb_addr = rba;
      v.e_ra = era; v.e_rav = erav; v.e_rb = erb; v.e_rbv = erbv; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one vector at the falling edge, push its expectation, and
   // compare the scoreboard head just after the following rising edge.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      rst = v.rst; w_en = v.w_en; w_addr = v.w_addr; w_data = v.w_data; w_be = v.w_be;
      inv_en = v.inv_en; inv_addr = v.inv_addr; ra_en = v.ra_en; ra_addr = v.ra_addr;
      rb_en = v.rb_en; rb_addr = v.rb_addr;
      e.ra = v.e_ra; e.rav = v.e_rav; e.rb = v.e_rb; e.rbv = v.e_rbv; e.cnt = v.e_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, " scoreboard empty"}, 16'd1, 16'd0);
      end else begin
         e = sb.pop_front();
         check({tag, " ra_data"}, ra_data, e.ra);
         check({tag, " ra_vld"}, 16'(ra_vld), 16'(e.rav));
         check({tag, " rb_data"}, rb_data, e.rb);
         check({tag, " rb_vld"}, 16'(rb_vld), 16'(e.rbv));
         check({tag, " valid_cnt"}, 16'(valid_cnt), 16'(e.cnt));
      end
   endtask

   task automatic check_z(input string tag, input logic [15:0] era, input logic erav,
                          input logic [15:0] erb, input logic erbv, input logic [3:0] ecnt);
      check({tag, " z ra_data"}, z_ra_data, era);
      check({tag, " z ra_vld"}, 16'(z_ra_vld), 16'(erav));
      check({tag, " z rb_data"}, z_rb_data, erb);
      check({tag, " z rb_vld"}, 16'(z_rb_vld), 16'(erbv));
      check({tag, " z valid_cnt"}, 16'(z_valid_cnt), 16'(ecnt));
   endtask

   initial begin
      rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = '0; w_be = '0;
      inv_en = 1'b0; inv_addr = '0; ra_en = 1'b0; ra_addr = '0; rb_en = 1'b0; rb_addr = '0;

      // Reset for two cycles, then read address 5.
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(1, 1, 3, 16'hFFFF, 2'b11, 0, 0, 1, 3, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));

      // Counter bounds: fill, rewrite, drain, over-drain.
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(0, 1, 3'(i), 16'(i * 16'h1111), 2'b11, 0, 0, 0, 0, 1, 3'(i),
                           16'h0000, 0, 16'(i * 16'h1111), 1, 4'(i + 1)));
      end
      vecs.push_back(mk(0, 1, 4, 16'h4444, 2'b11, 0, 0, 0, 0, 1, 4, 16'h0000, 0, 16'h4444, 1, 8));
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3'(i), 0, 0, 1, 3'(i),
                           16'h0000, 0, 16'h0000, 0, 4'(7 - i)));
      end
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0));

      // Byte-merge write with bypass on port B.
      vecs.push_back(mk(0, 1, 3, 16'h1234, 2'b11, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(0, 1, 3, 16'hABCD, 2'b01, 0, 0, 0, 0, 1, 3, 16'h0000, 0, 16'h12CD, 1, 1));

      // Write/invalidate collision, then split addresses, then zero-strobe write.
      vecs.push_back(mk(0, 1, 2, 16'h00FF, 2'b11, 0, 0, 1, 2, 0, 0, 16'h00FF, 1, 16'h12CD, 1, 2));
      vecs.push_back(mk(0, 1, 2, 16'h5500, 2'b10, 1, 2, 1, 2, 0, 0, 16'h55FF, 1, 16'h12CD, 1, 2));
      vecs.push_back(mk(0, 1, 7, 16'h7777, 2'b11, 1, 3, 1, 3, 1, 7, 16'h0000, 0, 16'h7777, 1, 2));
      vecs.push_back(mk(0, 1, 5, 16'hFFFF, 2'b00, 0, 0, 1, 5, 0, 0, 16'h0000, 1, 16'h7777, 1, 3));
      // Both ports on the write address see the same bypassed data.
      vecs.push_back(mk(0, 1, 2, 16'hA5A5, 2'b01, 0, 0, 1, 2, 1, 2, 16'h55A5, 1, 16'h55A5, 1, 3));

      // Read hold on port A while entry 6 is rewritten.
      vecs.push_back(mk(0, 1, 6, 16'h0A0A, 2'b11, 0, 0, 1, 6, 0, 0, 16'h0A0A, 1, 16'h55A5, 1, 4));
      vecs.push_back(mk(0, 1, 6, 16'hFFFF, 2'b11, 0, 0, 0, 6, 0, 0, 16'h0A0A, 1, 16'h55A5, 1, 4));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 16'h0A0A, 1, 16'h55A5, 1, 4));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 16'hFFFF, 1, 16'h55A5, 1, 4));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Hardwired-zero instance, with reset landing on pending writes.
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0), "z_rst");
      check_z("z_rst", 16'h0000, 0, 16'h0000, 0, 0);
      apply(mk(0, 1, 0, 16'hBEEF, 2'b11, 0, 0, 1, 0, 1, 0, 16'hBEEF, 1, 16'hBEEF, 1, 1), "z_w0");
      check_z("z_w0", 16'h0000, 1, 16'h0000, 1, 0);
      apply(mk(0, 1, 1, 16'h1357, 2'b11, 1, 0, 1, 1, 0, 0, 16'h1357, 1, 16'hBEEF, 1, 1), "z_w1");
      check_z("z_w1", 16'h1357, 1, 16'h0000, 1, 1);
      apply(mk(1, 1, 2, 16'h2222, 2'b11, 0, 0, 1, 2, 1, 0, 16'h0000, 0, 16'h0000, 0, 0), "z_mid_rst");
      check_z("z_mid_rst", 16'h0000, 0, 16'h0000, 0, 0);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 16'h0000, 0, 16'h0000, 0, 0), "z_after");
      check_z("z_after", 16'h0000, 1, 16'h0000, 0, 0);

      check("scoreboard drained", 16'(sb.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
